decode_issue_stage: RTL and testbench

//   Decode/issue stage directly upstream of the register bank. Takes fetched
//   32-bit MIPS instructions over a valid/ready handshake and drives the bank

---
 rtl/decode_issue_if.sv | 32 +++
 rtl/decode_issue_stage.sv | 139 +++++++++++++
 tb/tb_decode_issue_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Instruction-in / issued-bundle-out handshake bundle of the decode/issue stage.
// slave: the stage itself; master: the upstream fetch and downstream ALU side.
interface decode_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [DATA_W-1:0] out_imm;
  logic [5:0]        out_opcode;
  logic [5:0]        out_funct;
  logic [4:0]        out_shamt;
  logic              out_wreg;
  logic [REG_AW-1:0] out_waddr;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_imm,
           out_opcode, out_funct, out_shamt, out_wreg, out_waddr
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_imm,
           out_opcode, out_funct, out_shamt, out_wreg, out_waddr
  );
endinterface

// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage with a pending-write scoreboard and RAW/WAW stall.
// Optional macro FWD_EN: forward write-back data to a pending source operand.
module decode_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_issue_if.slave     io,
  output logic [REG_AW-1:0] rb_ar1,
  output logic [REG_AW-1:0] rb_ar2,
  input  logic [DATA_W-1:0] rb_dr1,
  input  logic [DATA_W-1:0] rb_dr2,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   sb, sb_nxt;
  logic [5:0]        opc_p0;
  logic [REG_AW-1:0] rs_p0, rt_p0, rd_p0, dst_p0;
  logic              use_rs_p0, use_rt_p0, dst_vld_p0, wreg_p0;
  logic              byp1_p0, byp2_p0, haz_p0, issue_p0, slot_free_p0;
  logic [DATA_W-1:0] op1_p0, op2_p0;

  logic              vld_p1, wreg_p1;
  logic [DATA_W-1:0] op1_p1, op2_p1, imm_p1;
  logic [5:0]        opc_p1, funct_p1;
  logic [4:0]        shamt_p1;
  logic [REG_AW-1:0] waddr_p1;

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] v);
    return DATA_W'(v);
  endfunction

  // Register 0 is hardwired, so it never counts as pending.
  function automatic logic pending(input logic [NREG-1:0] s, input logic [REG_AW-1:0] a);
    return (a != '0) && s[a];
  endfunction

  // Stage p0: decode, hazard detection, handshake
  always_comb begin
    opc_p0     = io.in_instr[31:26];
    rs_p0      = REG_AW'(io.in_instr[25:21]);
    rt_p0      = REG_AW'(io.in_instr[20:16]);
    rd_p0      = REG_AW'(io.in_instr[15:11]);
    use_rs_p0  = 1'b1;
    use_rt_p0  = 1'b0;
    dst_vld_p0 = 1'b1;
    dst_p0     = rt_p0;
    case (opc_p0)
      6'h00: begin
        use_rt_p0 = 1'b1;
        dst_p0    = rd_p0;
      end
      6'h02: begin
        use_rs_p0  = 1'b0;
        dst_vld_p0 = 1'b0;
      end
      6'h04, 6'h2B: begin
        use_rt_p0  = 1'b1;
        dst_vld_p0 = 1'b0;
      end
      default: ;
    endcase
    wreg_p0 = dst_vld_p0 && (dst_p0 != '0);
  end

  always_comb begin
`ifdef FWD_EN
    byp1_p0 = use_rs_p0 && pending(sb, rs_p0) && wb_valid && (wb_addr == rs_p0);
    byp2_p0 = use_rt_p0 && pending(sb, rt_p0) && wb_valid && (wb_addr == rt_p0);
`else
    byp1_p0 = 1'b0;
    byp2_p0 = 1'b0;
`endif
    // Destination check is strict: a WAW waits for the older write to commit.
    haz_p0 = (use_rs_p0 && pending(sb, rs_p0) && !byp1_p0)
          || (use_rt_p0 && pending(sb, rt_p0) && !byp2_p0)
          || (wreg_p0 && pending(sb, dst_p0));
    slot_free_p0 = !vld_p1 || io.out_ready;
    issue_p0     = io.in_valid && slot_free_p0 && !haz_p0;
    op1_p0       = byp1_p0 ? wb_data : rb_dr1;
    op2_p0       = byp2_p0 ? wb_data : rb_dr2;
  end

  always_comb begin
    sb_nxt = sb;
    if (wb_valid) sb_nxt[wb_addr] = 1'b0;
    if (issue_p0 && wreg_p0) sb_nxt[dst_p0] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  assign rb_ar1      = rs_p0;
  assign rb_ar2      = rt_p0;
  assign io.in_ready = slot_free_p0 && !haz_p0;

  // Stage p1: issued bundle register toward the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb       <= '0;
      vld_p1   <= 1'b0;
      wreg_p1  <= 1'b0;
      op1_p1   <= '0;
      op2_p1   <= '0;
      imm_p1   <= '0;
      opc_p1   <= '0;
      funct_p1 <= '0;
      shamt_p1 <= '0;
      waddr_p1 <= '0;
    end else begin
      sb <= sb_nxt;
      if (issue_p0) begin
        vld_p1   <= 1'b1;
        wreg_p1  <= wreg_p0;
        op1_p1   <= op1_p0;
        op2_p1   <= op2_p0;
        imm_p1   <= sext16(io.in_instr[15:0]);
        opc_p1   <= opc_p0;
        funct_p1 <= io.in_instr[5:0];
        shamt_p1 <= io.in_instr[10:6];
        waddr_p1 <= wreg_p0 ? dst_p0 : '0;
      end else if (io.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign io.out_valid  = vld_p1;
  assign io.out_wreg   = wreg_p1;
  assign io.out_op1    = op1_p1;
  assign io.out_op2    = op2_p1;
  assign io.out_imm    = imm_p1;
  assign io.out_opcode = opc_p1;
  assign io.out_funct  = funct_p1;
  assign io.out_shamt  = shamt_p1;
  assign io.out_waddr  = waddr_p1;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: reset, decode, RAW/WAW stalls,
// backpressure hold and write-back release (with or without FWD_EN).
module tb_decode_issue_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] rb_ar1, rb_ar2;
  logic [DATA_W-1:0] rb_dr1, rb_dr2;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  int n_chk  = 0;
  int n_fail = 0;

  decode_issue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dif ();

  decode_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (dif),
    .rb_ar1   (rb_ar1),
    .rb_ar2   (rb_ar2),
    .rb_dr1   (rb_dr1),
    .rb_dr2   (rb_dr2),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_instr  = 32'h0;
    dif.out_ready = 1'b1;
    rb_dr1 = '0; rb_dr2 = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    tick; tick;
    chk("rst_vld",   dif.out_valid, 0);
    chk("rst_op1",   dif.out_op1,   0);
    chk("rst_waddr", dif.out_waddr, 0);
    chk("rst_wreg",  dif.out_wreg,  0);
    rst_n = 1'b1;
    #1 chk("rst_rdy", dif.in_ready, 1);

    // add $3,$1,$2
    dif.in_instr = 32'h00221820; dif.in_valid = 1'b1; rb_dr1 = 5; rb_dr2 = 7;
    #1;
    chk("add_ar1", rb_ar1, 1);
    chk("add_ar2", rb_ar2, 2);
    chk("add_rdy", dif.in_ready, 1);
    tick;
    chk("add_vld",   dif.out_valid,  1);
    chk("add_op1",   dif.out_op1,    5);
    chk("add_op2",   dif.out_op2,    7);
    chk("add_funct", dif.out_funct,  6'h20);
    chk("add_waddr", dif.out_waddr,  3);
    chk("add_wreg",  dif.out_wreg,   1);
    chk("add_opc",   dif.out_opcode, 0);
    chk("add_shamt", dif.out_shamt,  0);

    // sub $4,$3,$1 stalls on $3; reset mid-stall with the bundle held
    dif.in_instr = 32'h00612022; dif.out_ready = 1'b0;
    #1 chk("raw_rdy", dif.in_ready, 0);
    tick;
    chk("raw_hold_vld", dif.out_valid, 1);
    chk("raw_hold_op1", dif.out_op1, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_vld",   dif.out_valid, 0);
    chk("arst_waddr", dif.out_waddr, 0);
    tick;
    rst_n = 1'b1; rb_dr1 = 32'h21;
    #1 chk("arst_rdy", dif.in_ready, 1);
    tick;
    chk("arst_iss_vld",   dif.out_valid, 1);
    chk("arst_iss_waddr", dif.out_waddr, 4);
    chk("arst_iss_op1",   dif.out_op1, 32'h21);
    dif.in_valid = 1'b0; dif.out_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 4; wb_data = 32'h0;
    tick;
    wb_valid = 1'b0;
    chk("drain_vld", dif.out_valid, 0);

    // add $3 then sub $4,$3,$1 resolved by write-back of $3
    dif.in_instr = 32'h00221820; dif.in_valid = 1'b1; rb_dr1 = 5; rb_dr2 = 7;
    tick;
    dif.in_instr = 32'h00612022; rb_dr1 = 32'h11; rb_dr2 = 32'h22;
    #1 chk("sub_stall", dif.in_ready, 0);
    tick;
    chk("sub_stall_vld", dif.out_valid, 0);
    wb_valid = 1'b1; wb_addr = 3; wb_data = 32'h99;
`ifdef FWD_EN
    #1 chk("sub_fwd_rdy", dif.in_ready, 1);
    tick;
    wb_valid = 1'b0;
`else
    #1 chk("sub_wb_stall", dif.in_ready, 0);
    tick;
    wb_valid = 1'b0; rb_dr1 = 32'h99;
    #1 chk("sub_post_wb_rdy", dif.in_ready, 1);
    tick;
`endif
    chk("sub_vld",   dif.out_valid, 1);
    chk("sub_op1",   dif.out_op1, 32'h99);
    chk("sub_op2",   dif.out_op2, 32'h22);
    chk("sub_waddr", dif.out_waddr, 4);
    chk("sub_funct", dif.out_funct, 6'h22);

    // Backpressure for 3 cycles, next instr addi $5,$0,-1 waits
    dif.out_ready = 1'b0; dif.in_instr = 32'h2005FFFF;
    #1 chk("bp_rdy", dif.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_vld",   dif.out_valid, 1);
      chk("bp_op1",   dif.out_op1, 32'h99);
      chk("bp_waddr", dif.out_waddr, 4);
      chk("bp_rdy_n", dif.in_ready, 0);
    end
    dif.out_ready = 1'b1; rb_dr1 = 0;
    #1 chk("bp_release_rdy", dif.in_ready, 1);
    tick;
    chk("addi_vld",   dif.out_valid, 1);
    chk("addi_imm",   dif.out_imm, 32'hFFFFFFFF);
    chk("addi_waddr", dif.out_waddr, 5);
    chk("addi_wreg",  dif.out_wreg, 1);
    chk("addi_opc",   dif.out_opcode, 6'h08);

    // add $0,$1,$2: no register write
    dif.in_instr = 32'h00220020;
    #1 chk("add0_rdy", dif.in_ready, 1);
    tick;
    chk("add0_wreg",  dif.out_wreg, 0);
    chk("add0_waddr", dif.out_waddr, 0);

    // sw $2,4($1)
    dif.in_instr = 32'hAC220004;
    tick;
    chk("sw_wreg", dif.out_wreg, 0);
    chk("sw_imm",  dif.out_imm, 4);
    chk("sw_opc",  dif.out_opcode, 6'h2B);

    // j reads nothing, so pending $4/$5 do not block it
    dif.in_instr = 32'h08000010;
    #1 chk("j_rdy", dif.in_ready, 1);
    tick;
    chk("j_opc",  dif.out_opcode, 6'h02);
    chk("j_wreg", dif.out_wreg, 0);

    // addi $4,$0,1 while $4 pending: WAW stall
    dif.in_instr = 32'h20040001;
    #1 chk("waw_rdy", dif.in_ready, 0);

    // beq $1,$5 with $5 pending
    dif.in_instr = 32'h10250003; rb_dr2 = 32'h33;
    #1 chk("beq_stall", dif.in_ready, 0);
    tick;
    chk("beq_stall2", dif.in_ready, 0);
    chk("beq_out_vld", dif.out_valid, 0);
    wb_valid = 1'b1; wb_addr = 5; wb_data = 32'h55;
`ifdef FWD_EN
    #1 chk("beq_fwd_rdy", dif.in_ready, 1);
    tick;
    wb_valid = 1'b0;
`else
    #1 chk("beq_wb_stall", dif.in_ready, 0);
    tick;
    wb_valid = 1'b0; rb_dr2 = 32'h55;
    #1 chk("beq_post_wb_rdy", dif.in_ready, 1);
    tick;
`endif
    chk("beq_vld",  dif.out_valid, 1);
    chk("beq_op2",  dif.out_op2, 32'h55);
    chk("beq_opc",  dif.out_opcode, 6'h04);
    chk("beq_imm",  dif.out_imm, 3);
    chk("beq_wreg", dif.out_wreg, 0);

    dif.in_valid = 1'b0;
    tick;
    chk("end_vld", dif.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
